// File: rtl/fila_saida.sv
// Output-port FIFO behind the CPU OUT register: snoops writeOUT/saida, queues words, drains over valid/ready.
// Optional build macro FILA_SAIDA_OVF_COUNT_EN adds the saturating ovf_count port.
module fila_saida #(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              writeOUT,
    input  logic [15:0]       saida,
    input  logic              limpa,
    output logic              m_valid,
    output logic [15:0]       m_data,
    input  logic              m_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef FILA_SAIDA_OVF_COUNT_EN
    ,
    output logic [7:0]        ovf_count
`endif
);

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W-1:0] wrPtr;
    logic              pend;
    logic              pop;
    logic              push;
    logic              drop;

    // count never exceeds DEPTH (a power of two), so its MSB alone means full
    assign empty   = (count == '0);
    assign full    = count[ADDR_W];
    assign m_valid = !empty;
    assign m_data  = mem[rdPtr];

    assign pop  = m_valid & m_ready;
    assign push = pend & (!full | pop) & !limpa;
    assign drop = pend & full & !pop;

    // NOTE: storage has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= saida;
        end
    end

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            pend     <= 1'b0;
            overflow <= 1'b0;
        end else if (limpa) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            pend     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pend <= writeOUT;
            if (push) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (ADDR_W+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef FILA_SAIDA_OVF_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (limpa) begin
            ovf_count <= '0;
        end else if (drop && ovf_count != 8'hFF) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fila_saida.sv
// Directed self-checking bench for fila_saida; models the CPU OUT register in front of it.
// Define FILA_SAIDA_OVF_COUNT_EN to also exercise the drop counter.
module tb_fila_saida;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        writeOUT;
    logic [15:0] cpuData;
    logic [15:0] saida = '0;
    logic        limpa;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
`ifdef FILA_SAIDA_OVF_COUNT_EN
    logic [7:0]  ovf_count;
`endif

    int nChecks = 0;
    int nBad    = 0;

    always #5 clk = ~clk;

    // CPU OUT register: loads on the edge that samples writeOUT
    always @(posedge clk) begin
        if (writeOUT) saida <= cpuData;
    end

    fila_saida dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .writeOUT (writeOUT),
        .saida    (saida),
        .limpa    (limpa),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
`ifdef FILA_SAIDA_OVF_COUNT_EN
        ,
        .ovf_count(ovf_count)
`endif
    );

    task automatic confere(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n back-to-back writes starting at base, then one idle cycle so the last push lands
    task automatic enche(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            writeOUT = 1'b1;
            cpuData  = base + 16'(i);
            tick();
        end
        writeOUT = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] exp3(input int p);
        return (p < 8) ? 16'(16'h0201 + p) : 16'(16'h0100 + p - 8);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        rst_n    = 1'b0;
        writeOUT = 1'b0;
        cpuData  = '0;
        limpa    = 1'b0;
        m_ready  = 1'b0;
        #1;
        confere("rst_valid", m_valid, 0);
        confere("rst_empty", empty, 1);
        confere("rst_full", full, 0);
        confere("rst_count", count, 0);
        confere("rst_ovf", overflow, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 1: single word, two-cycle latency, then pop
        writeOUT = 1'b1;
        cpuData  = 16'h00A5;
        tick();
        writeOUT = 1'b0;
        confere("t1_lat1", m_valid, 0);
        tick();
        confere("t1_valid", m_valid, 1);
        confere("t1_data", m_data, 16'h00A5);
        confere("t1_count", count, 1);
        tick();
        confere("t1_hold", m_data, 16'h00A5);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        confere("t1_empty", empty, 1);
        confere("t1_count0", count, 0);

        // 2: fill, drop the ninth word, drain in order
        enche(16'h0001, 8);
        confere("t2_full", full, 1);
        confere("t2_count", count, 8);
        confere("t2_noovf", overflow, 0);
        writeOUT = 1'b1;
        cpuData  = 16'h0009;
        tick();
        writeOUT = 1'b0;
        tick();
        confere("t2_ovf", overflow, 1);
        confere("t2_count9", count, 8);
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            confere("t2_drain", m_data, i);
            tick();
        end
        m_ready = 1'b0;
        confere("t2_empty", empty, 1);
        confere("t2_sticky", overflow, 1);
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        confere("t2_ovfclr", overflow, 0);

        // 3: full FIFO, push and pop every cycle, nothing dropped
        enche(16'h0201, 8);
        p = 0;
        for (int j = 0; j < 16; j++) begin
            writeOUT = 1'b1;
            cpuData  = 16'(16'h0100 + j);
            m_ready  = (j > 0);
            if (j > 0) begin
                confere("t3_count", count, 8);
                confere("t3_data", m_data, exp3(p));
                p++;
            end
            tick();
        end
        writeOUT = 1'b0;
        m_ready  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (m_valid) begin
                confere("t3_data", m_data, exp3(p));
                p++;
            end
            tick();
        end
        m_ready = 1'b0;
        confere("t3_pops", p, 24);
        confere("t3_noovf", overflow, 0);
        confere("t3_empty", empty, 1);

        // 4: 1-in/1-out streaming across pointer wrap
        p = 0;
        m_ready = 1'b1;
        for (int j = 0; j < 23; j++) begin
            writeOUT = (j < 20);
            cpuData  = 16'(16'h0300 + j);
            if (m_valid) begin
                confere("t4_data", m_data, 16'(16'h0300 + p));
                p++;
            end
            confere("t4_cnt_le1", count <= 1, 1);
            tick();
        end
        m_ready = 1'b0;
        confere("t4_pops", p, 20);
        confere("t4_empty", empty, 1);

        // 5: flush beats a pending push and a pop in the same cycle
        enche(16'h0400, 5);
        writeOUT = 1'b1;
        cpuData  = 16'h04FF;
        tick();
        writeOUT = 1'b0;
        limpa    = 1'b1;
        m_ready  = 1'b1;
        confere("t5_pre", count, 5);
        tick();
        limpa   = 1'b0;
        m_ready = 1'b0;
        confere("t5_empty", empty, 1);
        confere("t5_count", count, 0);
        confere("t5_ovf", overflow, 0);
        tick();
        confere("t5_nopush", empty, 1);

        // 5b: asynchronous reset mid-stream
        enche(16'h0500, 3);
        writeOUT = 1'b1;
        m_ready  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        confere("t5_rvalid", m_valid, 0);
        confere("t5_rcount", count, 0);
        confere("t5_rempty", empty, 1);
        writeOUT = 1'b0;
        m_ready  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        confere("t5_rpend", empty, 1);

`ifdef FILA_SAIDA_OVF_COUNT_EN
        // 6: drop counter counts, saturates, and clears on flush
        enche(16'h0600, 8);
        for (int j = 0; j < 10; j++) begin
            writeOUT = 1'b1;
            tick();
        end
        writeOUT = 1'b0;
        tick();
        confere("t6_ovf10", ovf_count, 10);
        for (int j = 0; j < 290; j++) begin
            writeOUT = 1'b1;
            tick();
        end
        writeOUT = 1'b0;
        tick();
        confere("t6_sat", ovf_count, 255);
        confere("t6_sticky", overflow, 1);
        confere("t6_count", count, 8);
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        confere("t6_clr", ovf_count, 0);
        confere("t6_empty", empty, 1);
`endif

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
